cdc_read_request: RTL and testbench
===================================

# cdc_read_request

Two-domain read-request bridge. A requester in the `w_clk` domain issues an address, the responder in the `r_clk` domain services it, and the read data is returned to `w_clk`. Toggle (2-phase) handshaking is used in both directions, with one transaction outstanding at a time. It sits between a `w_clk` control/CSR master and register banks or status logic clocked by `r_clk`.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, request address width
- `DATA_WIDTH`, 32, response data width
- `SYNC_STAGES`, 2, flops per control synchronizer (≥2)
- `TIMEOUT_CYCLES`, 1024, `w_clk` cycles before timeout (≥1; used only with `CDC_READ_REQUEST_TIMEOUT_EN`)

Ports:
- `w_clk` in 1: requester clock
- `w_reset_n` in 1: requester reset, asynchronous, active-low
- `r_clk` in 1: responder clock
- `r_reset_n` in 1: responder reset, asynchronous, active-low
- `w_req_valid` in 1: request strobe, accepted when `w_req_ready`=1
- `w_req_ready` out 1: no transaction outstanding
- `w_req_addr` in `ADDR_WIDTH`: request address
- `w_rsp_valid` out 1: one-cycle response pulse
- `w_rsp_data` out `DATA_WIDTH`: response data, held until the next response
- `w_rsp_timeout` out 1: response was a timeout (macro only)
- `r_req_valid` out 1: one-cycle new-request pulse
- `r_req_addr` out `ADDR_WIDTH`: captured address, stable while pending
- `r_req_pending` out 1: request awaiting response
- `r_rsp_valid` in 1: responder data strobe
- `r_rsp_data` in `DATA_WIDTH`: responder data

## Operation
- **w FSM states:** `IDLE`, `WAIT`, plus `DRAIN` (macro only). `w_req_ready` = (state==`IDLE`).
- **`IDLE` + `w_req_valid`:**
  - Register `w_req_addr` into `w_addr_reg`.
  - Invert `w_req_toggle`.
  - Go to `WAIT`.
- **r side:** `w_req_toggle` is synchronized to `r_clk` and edge-detected against a delayed copy. On an edge:
  - `r_req_valid`=1 for one cycle.
  - `r_req_addr` <= `w_addr_reg`. This is stable by protocol.
  - `r_req_pending` <= 1.
- **Response accept:** `r_rsp_valid` is accepted only while `r_req_pending`=1, and the responder may hold it off any number of cycles. On accept:
  - `r_rsp_reg` <= `r_rsp_data`.
  - Invert `r_rsp_toggle`.
  - `r_req_pending` <= 0.
- `r_rsp_valid` while not pending is ignored.
- **Response return:** `r_rsp_toggle` is synchronized to `w_clk` and edge-detected.
  - In `WAIT`: `w_rsp_valid`=1, `w_rsp_data` <= `r_rsp_reg`, go to `IDLE`.
  - In `DRAIN`: the data is discarded with no pulse, go to `IDLE`.
- **Reset values:**
  - `w_req_ready`=1 (`IDLE`).
  - `w_rsp_valid`, `w_rsp_timeout`, `w_rsp_data`, `r_req_valid`, `r_req_pending`, `r_req_addr` all 0.
  - Both toggles and both synchronizers 0.
- **Reset mid-transaction:** both resets must be asserted together, since toggle phases are only consistent after a joint reset.
  - A single-domain reset is out of spec.
  - With the timeout macro enabled, a hung `w` side still returns a timeout response; the system must then reset both domains.

## Timing
- `r_req_valid` rises `SYNC_STAGES`+1 `r_clk` edges after the `w_req_toggle` change, plus ≤1 `r_clk` of phase uncertainty.
- `w_rsp_valid` rises `SYNC_STAGES`+1 `w_clk` edges after the `r_rsp_toggle` change, plus ≤1 `w_clk`.
- `r_req_pending` rises in the same cycle as `r_req_valid`, so `r_rsp_valid` may be accepted in that same cycle.
- `w_rsp_valid` and the return to `IDLE` take effect on the same edge: `w_req_ready`=1 during the response pulse, and a new request can be accepted in that cycle.
- All outputs are registered except `w_req_ready`, which is decoded from a registered state.

## Configuration
- **Macro:** `CDC_READ_REQUEST_TIMEOUT_EN`.
- **Defined:**
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to `WAIT` and increments each cycle in `WAIT`.
  - At `TIMEOUT_CYCLES`-1: `w_rsp_valid`=1, `w_rsp_timeout`=1, `w_rsp_data`=0, go to `DRAIN`. `w_req_ready` stays 0 until the late response toggle arrives.
  - A response edge in the expiry cycle wins, giving a normal response.
  - `w_rsp_timeout`=0 on every normal response.
- **Undefined:** no counter, no `DRAIN` state, `w_rsp_timeout` tied to 0, and `WAIT` waits indefinitely.

## Structure
- **Package `cdc_pkg`:**
  - `cdc_rr_state_e` (`IDLE`/`WAIT`/`DRAIN`).
  - `CDC_MIN_SYNC_STAGES`=2, with an elaboration assertion against `SYNC_STAGES`.
- **Sub-module:** existing `cdc_sync`, instantiated twice (req toggle into `r_clk`, rsp toggle into `w_clk`) with `INITIAL_VAL`=0 and each domain's own reset.

## Test plan
- **Basic read:** `w_clk`=100 MHz, `r_clk`=37 MHz, addr 0x1234. Responder answers 0xDEADBEEF after 5 `r_clk`. Required: one `r_req_valid` with `r_req_addr`=0x1234, then one `w_rsp_valid` with `w_rsp_data`=0xDEADBEEF.
- **Back-to-back:** 200 random reads with `w_req_valid` held high, clock ratios 1:3 and 3:1. Required: responses in order, data matches, exactly one `r_req_valid` per request, `w_req_ready`=0 while outstanding.
- **Same-cycle reply:** responder drives `r_rsp_valid` in the `r_req_valid` cycle. Required: accepted, `r_req_pending` drops the next cycle.
- **Spurious strobe:** `r_rsp_valid` pulsed with no pending request. Required: no `w_rsp_valid`, toggle unchanged.
- **Timeout (macro on, `TIMEOUT_CYCLES`=16):** responder silent for 40 `w_clk`, then answers 0xA5. Required: `w_rsp_valid`+`w_rsp_timeout` at cycle 16 with data 0, the late 0xA5 is discarded, `w_req_ready` returns after the drain, and the next read completes normally.
- **Joint reset mid-`WAIT`:** required: all outputs return to reset values and the next read succeeds.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and limits for the two-domain read-request bridge.
// State encoding of the requester-side FSM lives here.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } cdc_rr_state_e;

  localparam int CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop level synchronizer for a single control bit.
// Reset value is parameterised so toggle phases start known.
module cdc_sync
  import cdc_pkg::*;
#(
  parameter int   STAGES      = 2,
  parameter logic INITIAL_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_stages
    $error("cdc_sync: STAGES below minimum");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{INITIAL_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_read_request.sv
// Toggle-handshake read bridge: w_clk requester, r_clk responder.
// Optional response timeout: define CDC_READ_REQUEST_TIMEOUT_EN.
module cdc_read_request
  import cdc_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  w_clk,
  input  logic                  w_reset_n,
  input  logic                  r_clk,
  input  logic                  r_reset_n,
  input  logic                  w_req_valid,
  output logic                  w_req_ready,
  input  logic [ADDR_WIDTH-1:0] w_req_addr,
  output logic                  w_rsp_valid,
  output logic [DATA_WIDTH-1:0] w_rsp_data,
  output logic                  w_rsp_timeout,
  output logic                  r_req_valid,
  output logic [ADDR_WIDTH-1:0] r_req_addr,
  output logic                  r_req_pending,
  input  logic                  r_rsp_valid,
  input  logic [DATA_WIDTH-1:0] r_rsp_data
);

  if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_sync
    $error("cdc_read_request: SYNC_STAGES below minimum");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cdc_read_request: TIMEOUT_CYCLES must be >= 1");
  end

  cdc_rr_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  req_tog_q, req_tog_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_sync;
  logic                  rsp_dly_q;
  logic                  rsp_edge;

  logic                  req_sync;
  logic                  req_dly_q;
  logic                  req_edge;
  logic                  accept;
  logic                  r_valid_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic                  r_pend_q;
  logic [DATA_WIDTH-1:0] r_rsp_reg_q;
  logic                  r_rsp_tog_q;

`ifdef CDC_READ_REQUEST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
`endif

  cdc_sync #(
    .STAGES     (SYNC_STAGES),
    .INITIAL_VAL(1'b0)
  ) u_req_sync (
    .clk_i (r_clk),
    .rst_ni(r_reset_n),
    .d_i   (req_tog_q),
    .q_o   (req_sync)
  );

  cdc_sync #(
    .STAGES     (SYNC_STAGES),
    .INITIAL_VAL(1'b0)
  ) u_rsp_sync (
    .clk_i (w_clk),
    .rst_ni(w_reset_n),
    .d_i   (r_rsp_tog_q),
    .q_o   (rsp_sync)
  );

  assign rsp_edge = rsp_sync ^ rsp_dly_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_tog_d   = req_tog_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`ifdef CDC_READ_REQUEST_TIMEOUT_EN
    cnt_d       = cnt_q;
    to_d        = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (w_req_valid) begin
          addr_d    = w_req_addr;
          req_tog_d = ~req_tog_q;
          state_d   = WAIT;
`ifdef CDC_READ_REQUEST_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      WAIT: begin
        // A response edge in the expiry cycle still wins.
        if (rsp_edge) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = r_rsp_reg_q;
          state_d     = IDLE;
`ifdef CDC_READ_REQUEST_TIMEOUT_EN
          to_d        = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          to_d        = 1'b1;
          state_d     = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
`ifdef CDC_READ_REQUEST_TIMEOUT_EN
      DRAIN: begin
        if (rsp_edge) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      req_tog_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_dly_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_tog_q   <= req_tog_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_dly_q   <= rsp_sync;
    end
  end

`ifdef CDC_READ_REQUEST_TIMEOUT_EN
  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign w_rsp_timeout = to_q;
`else
  assign w_rsp_timeout = 1'b0;
`endif

  assign w_req_ready = (state_q == IDLE);
  assign w_rsp_valid = rsp_valid_q;
  assign w_rsp_data  = rsp_data_q;

  assign req_edge = req_sync ^ req_dly_q;
  assign accept   = r_rsp_valid & r_pend_q;

  // addr_q is held by the w FSM until the response returns.
  always_ff @(posedge r_clk or negedge r_reset_n) begin
    if (!r_reset_n) begin
      req_dly_q   <= 1'b0;
      r_valid_q   <= 1'b0;
      r_addr_q    <= '0;
      r_pend_q    <= 1'b0;
      r_rsp_reg_q <= '0;
      r_rsp_tog_q <= 1'b0;
    end else begin
      req_dly_q <= req_sync;
      r_valid_q <= req_edge;
      if (req_edge) begin
        r_addr_q <= addr_q;
        r_pend_q <= 1'b1;
      end else if (accept) begin
        r_pend_q <= 1'b0;
      end
      if (accept) begin
        r_rsp_reg_q <= r_rsp_data;
        r_rsp_tog_q <= ~r_rsp_tog_q;
      end
    end
  end

  assign r_req_valid   = r_valid_q;
  assign r_req_addr    = r_addr_q;
  assign r_req_pending = r_pend_q;

endmodule

// File: tb/tb_cdc_read_request.sv
// Randomized bench for cdc_read_request with a queue-based model
// of the request/response protocol across both clock domains.
`timescale 1ns/1ps
module tb_cdc_read_request;

  localparam int AW = 16;
  localparam int DW = 32;
`ifdef CDC_READ_REQUEST_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic          w_clk = 1'b0;
  logic          r_clk = 1'b0;
  logic          w_reset_n = 1'b0;
  logic          r_reset_n = 1'b0;
  logic          w_req_valid = 1'b0;
  logic          w_req_ready;
  logic [AW-1:0] w_req_addr = '0;
  logic          w_rsp_valid;
  logic [DW-1:0] w_rsp_data;
  logic          w_rsp_timeout;
  logic          r_req_valid;
  logic [AW-1:0] r_req_addr;
  logic          r_req_pending;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data;

  realtime w_half = 5.0;
  realtime r_half = 13.5;

  always #(w_half) w_clk = ~w_clk;
  always #(r_half) r_clk = ~r_clk;

  cdc_read_request #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .w_clk        (w_clk),
    .w_reset_n    (w_reset_n),
    .r_clk        (r_clk),
    .r_reset_n    (r_reset_n),
    .w_req_valid  (w_req_valid),
    .w_req_ready  (w_req_ready),
    .w_req_addr   (w_req_addr),
    .w_rsp_valid  (w_rsp_valid),
    .w_rsp_data   (w_rsp_data),
    .w_rsp_timeout(w_rsp_timeout),
    .r_req_valid  (r_req_valid),
    .r_req_addr   (r_req_addr),
    .r_req_pending(r_req_pending),
    .r_rsp_valid  (r_rsp_valid),
    .r_rsp_data   (r_rsp_data)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_issued = 0;
  int n_rsp = 0;
  int n_rvalid = 0;
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_data = '0;
  logic          exp_to = 1'b0;

  bit            resp_en = 1'b1;
  int            fix_dly = -1;
  bit            fix_data_en = 1'b0;
  logic [DW-1:0] fix_data = '0;
  bit            inj_req = 1'b0;
  logic [DW-1:0] inj_data = '0;

  // Responder: answers each new request after a delay; also injects raw strobes.
  initial begin
    int d;
    logic [DW-1:0] v;
    r_rsp_valid = 1'b0;
    r_rsp_data  = '0;
    forever begin
      @(posedge r_clk); #1;
      if (inj_req) begin
        r_rsp_valid = 1'b1;
        r_rsp_data  = inj_data;
        inj_req     = 1'b0;
        @(posedge r_clk); #1;
        r_rsp_valid = 1'b0;
      end else if (r_req_valid && resp_en) begin
        d = (fix_dly < 0) ? int'($urandom_range(0, 8)) : fix_dly;
        v = fix_data_en ? fix_data : DW'($urandom);
        repeat (d) begin
          @(posedge r_clk); #1;
        end
        r_rsp_valid = 1'b1;
        r_rsp_data  = v;
        exp_q.push_back(v);
        @(posedge r_clk); #1;
        r_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    logic [AW-1:0] a;
    forever begin
      @(posedge r_clk); #1;
      if (r_req_valid === 1'b1) begin
        n_rvalid++;
        n_chk++;
        if (addr_q.size() == 0) begin
          $display("FAIL r_req_addr: unexpected r_req_valid addr=%h", r_req_addr);
        end else begin
          a = addr_q.pop_front();
          if (r_req_addr !== a)
            $display("FAIL r_req_addr: got %h want %h", r_req_addr, a);
          else
            n_pass++;
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] e;
    forever begin
      @(posedge w_clk); #1;
      if (w_rsp_valid === 1'b1) begin
        n_rsp++;
        last_data = w_rsp_data;
        n_chk++;
        if (w_rsp_timeout !== exp_to)
          $display("FAIL w_rsp_timeout: got %b want %b", w_rsp_timeout, exp_to);
        else
          n_pass++;
        n_chk++;
        if (w_rsp_timeout === 1'b1) begin
          if (w_rsp_data !== '0)
            $display("FAIL timeout_data: got %h want 0", w_rsp_data);
          else
            n_pass++;
        end else if (exp_q.size() == 0) begin
          $display("FAIL w_rsp_data: unexpected response data=%h", w_rsp_data);
        end else begin
          e = exp_q.pop_front();
          if (w_rsp_data !== e)
            $display("FAIL w_rsp_data: got %h want %h", w_rsp_data, e);
          else
            n_pass++;
        end
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Caller must be #1 after a w_clk edge.
  task automatic do_read(input logic [AW-1:0] a, input bit hold);
    int k;
    w_req_valid = 1'b1;
    w_req_addr  = a;
    k = 0;
    while (w_req_ready !== 1'b1 && k < 4000) begin
      @(posedge w_clk); #1;
      k++;
    end
    if (k >= 4000) begin
      n_chk++;
      $display("FAIL req_accept: ready=%b after %0d cycles, want 1", w_req_ready, k);
      w_req_valid = 1'b0;
      return;
    end
    @(posedge w_clk); #1;
    addr_q.push_back(a);
    n_issued++;
    n_chk++;
    if (w_req_ready !== 1'b0)
      $display("FAIL ready_outstanding: got %b want 0", w_req_ready);
    else
      n_pass++;
    if (!hold) w_req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    do begin
      @(posedge w_clk); #1;
      k++;
    end while (n_rsp != n_issued && k < 20000);
    if (n_rsp != n_issued) begin
      n_chk++;
      $display("FAIL %s_done: responses=%0d want %0d", tag, n_rsp, n_issued);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_chk++;
    if (w_req_ready !== 1'b1)
      $display("FAIL %s_ready: got %b want 1", tag, w_req_ready);
    else n_pass++;
    n_chk++;
    if (w_rsp_valid !== 1'b0)
      $display("FAIL %s_rsp_valid: got %b want 0", tag, w_rsp_valid);
    else n_pass++;
    n_chk++;
    if (w_rsp_data !== '0)
      $display("FAIL %s_rsp_data: got %h want 0", tag, w_rsp_data);
    else n_pass++;
    n_chk++;
    if (w_rsp_timeout !== 1'b0)
      $display("FAIL %s_timeout: got %b want 0", tag, w_rsp_timeout);
    else n_pass++;
    n_chk++;
    if (r_req_valid !== 1'b0)
      $display("FAIL %s_r_valid: got %b want 0", tag, r_req_valid);
    else n_pass++;
    n_chk++;
    if (r_req_pending !== 1'b0)
      $display("FAIL %s_pending: got %b want 0", tag, r_req_pending);
    else n_pass++;
    n_chk++;
    if (r_req_addr !== '0)
      $display("FAIL %s_r_addr: got %h want 0", tag, r_req_addr);
    else n_pass++;
  endtask

  task automatic test_reset();
    w_reset_n = 1'b0;
    r_reset_n = 1'b0;
    #100;
    check_reset_vals("reset");
    #3 w_reset_n = 1'b1;
    #4 r_reset_n = 1'b1;
    @(posedge w_clk); #1;
  endtask

  task automatic test_basic();
    int base;
    w_half = 5.0;
    r_half = 13.5;
    fix_dly = 5;
    fix_data_en = 1'b1;
    fix_data = 32'hDEADBEEF;
    base = n_rvalid;
    @(posedge w_clk); #1;
    do_read(16'h1234, 1'b0);
    wait_done("basic");
    n_chk++;
    if (n_rvalid - base != 1)
      $display("FAIL basic_rvalid_count: got %0d want 1", n_rvalid - base);
    else n_pass++;
    n_chk++;
    if (last_data !== 32'hDEADBEEF)
      $display("FAIL basic_data: got %h want deadbeef", last_data);
    else n_pass++;
    fix_dly = -1;
    fix_data_en = 1'b0;
  endtask

  task automatic test_back_to_back(input realtime wh, input realtime rh);
    int base;
    w_half = wh;
    r_half = rh;
    base = n_rvalid;
    @(posedge w_clk); #1;
    for (int i = 0; i < 200; i++) begin
      do_read(AW'($urandom), i < 199);
    end
    wait_done("b2b");
    n_chk++;
    if (n_rvalid - base != 200)
      $display("FAIL b2b_rvalid_count: got %0d want 200", n_rvalid - base);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0 || addr_q.size() != 0)
      $display("FAIL b2b_leftover: got %0d/%0d want 0/0", exp_q.size(), addr_q.size());
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    int k;
    w_half = 5.0;
    r_half = 13.5;
    fix_dly = 0;
    @(posedge w_clk); #1;
    do_read(AW'($urandom), 1'b0);
    k = 0;
    do begin
      @(posedge r_clk); #2;
      k++;
    end while (r_req_valid !== 1'b1 && k < 100);
    n_chk++;
    if (r_req_pending !== 1'b1 || r_req_valid !== 1'b1)
      $display("FAIL same_pending_rise: valid=%b pending=%b want 1/1",
               r_req_valid, r_req_pending);
    else n_pass++;
    @(posedge r_clk); #2;
    n_chk++;
    if (r_req_pending !== 1'b0)
      $display("FAIL same_pending_drop: got %b want 0", r_req_pending);
    else n_pass++;
    wait_done("same");
    fix_dly = -1;
  endtask

  task automatic test_spurious();
    int base;
    @(posedge w_clk); #1;
    base = n_rsp;
    inj_data = DW'($urandom);
    inj_req = 1'b1;
    repeat (40) @(posedge w_clk);
    #1;
    n_chk++;
    if (n_rsp != base)
      $display("FAIL spurious_rsp: got %0d responses want 0", n_rsp - base);
    else n_pass++;
    n_chk++;
    if (r_req_pending !== 1'b0)
      $display("FAIL spurious_pending: got %b want 0", r_req_pending);
    else n_pass++;
    do_read(AW'($urandom), 1'b0);
    wait_done("post_spurious");
  endtask

`ifdef CDC_READ_REQUEST_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    w_half = 5.0;
    r_half = 13.5;
    resp_en = 1'b0;
    exp_to = 1'b1;
    @(posedge w_clk); #1;
    do_read(AW'($urandom), 1'b0);
    k = 0;
    do begin
      @(posedge w_clk); #1;
      k++;
    end while (w_rsp_valid !== 1'b1 && k < 200);
    n_chk++;
    if (k != TO)
      $display("FAIL timeout_cycle: got %0d want %0d", k, TO);
    else n_pass++;
    n_chk++;
    if (w_req_ready !== 1'b0)
      $display("FAIL timeout_ready: got %b want 0", w_req_ready);
    else n_pass++;
    repeat (40 - TO) @(posedge w_clk);
    #1;
    n_chk++;
    if (w_req_ready !== 1'b0)
      $display("FAIL drain_ready: got %b want 0", w_req_ready);
    else n_pass++;
    inj_data = 32'h000000A5;
    inj_req = 1'b1;
    k = 0;
    do begin
      @(posedge w_clk); #1;
      k++;
    end while (w_req_ready !== 1'b1 && k < 500);
    n_chk++;
    if (w_req_ready !== 1'b1)
      $display("FAIL drain_done: ready=%b want 1", w_req_ready);
    else n_pass++;
    n_chk++;
    if (w_rsp_data !== '0)
      $display("FAIL drain_discard: data=%h want 0", w_rsp_data);
    else n_pass++;
    exp_to = 1'b0;
    resp_en = 1'b1;
    do_read(AW'($urandom), 1'b0);
    wait_done("post_timeout");
  endtask
`endif

  task automatic test_reset_mid_wait();
    int base;
    w_half = 5.0;
    r_half = 13.5;
    resp_en = 1'b0;
    @(posedge w_clk); #1;
    do_read(AW'($urandom) | AW'(1), 1'b0);
    repeat (12) @(posedge w_clk);
    #1;
    n_chk++;
    if (r_req_pending !== 1'b1)
      $display("FAIL midwait_pending: got %b want 1", r_req_pending);
    else n_pass++;
    w_reset_n = 1'b0;
    r_reset_n = 1'b0;
    #2;
    check_reset_vals("midreset");
    addr_q.delete();
    exp_q.delete();
    n_rsp = n_issued;
    #30 w_reset_n = 1'b1;
    r_reset_n = 1'b1;
    resp_en = 1'b1;
    base = n_rvalid;
    @(posedge w_clk); #1;
    do_read(AW'($urandom), 1'b0);
    wait_done("post_reset");
    n_chk++;
    if (n_rvalid - base != 1)
      $display("FAIL post_reset_rvalid: got %0d want 1", n_rvalid - base);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back(5.0, 15.0);
    test_back_to_back(15.0, 5.0);
    test_same_cycle();
    test_spurious();
`ifdef CDC_READ_REQUEST_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
